dsp_mac_pipe: RTL

Parametrised, pipelined signed/unsigned multiply-accumulate block, the next generation of our registered DSP multiplier. It adds configurable product pipeline depth, per-sample signedness, accumulate mode with clear, optional saturation with a sticky overflow flag, a valid strobe and a global clock enable. It sits in DSP datapaths such as FIR taps and dot products, between operand sources and result sinks.

---
 rtl/dsp_mac_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with optional saturation,
// sticky overflow, valid strobe and a global clock enable.
module dsp_mac_pipe #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int PIPE_STAGES = 1,
  parameter int SATURATE    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic                 is_signed,
  input  logic                 acc_mode,
  input  logic                 acc_clr,
  output logic [ACC_WIDTH-1:0] P,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  generate
    if (ACC_WIDTH < PW || PIPE_STAGES < 0 || PIPE_STAGES > 4 ||
        A_WIDTH < 2 || B_WIDTH < 2) begin : g_param_err
      $error("dsp_mac_pipe: illegal parameter combination");
    end
  endgenerate

  typedef struct packed {
    logic          vld;
    logic          sgn;
    logic          mode;
    logic          clr;
    logic [PW-1:0] prod;
  } stage_t;

  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic               sgn_q;
  logic               mode_q;
  logic               clr_q;
  logic               vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      mode_q <= 1'b0;
      clr_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else if (ce) begin
      a_q    <= A;
      b_q    <= B;
      sgn_q  <= is_signed;
      mode_q <= acc_mode;
      clr_q  <= acc_clr;
      vld_q  <= in_valid;
    end
  end

  // Operands widened to the full product width, so the low PW bits are exact.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  stage_t               st0;

  always_comb begin
    if (sgn_q) begin
      a_ext = PW'(signed'(a_q));
      b_ext = PW'(signed'(b_q));
    end else begin
      a_ext = PW'(a_q);
      b_ext = PW'(b_q);
    end
    st0.vld  = vld_q;
    st0.sgn  = sgn_q;
    st0.mode = mode_q;
    st0.clr  = clr_q;
    st0.prod = PW'(a_ext * b_ext);
  end

  stage_t tap;

  generate
    if (PIPE_STAGES == 0) begin : g_direct
      assign tap = st0;
    end else begin : g_pipe
      stage_t pipe_q [PIPE_STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
        end else if (ce) begin
          pipe_q[0] <= st0;
          for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign tap = pipe_q[PIPE_STAGES-1];
    end
  endgenerate

  logic [ACC_WIDTH-1:0] p_q;
  logic [ACC_WIDTH-1:0] p_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic                 vld_out_q;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   sum_s;
  logic [ACC_WIDTH:0]   sum_u;

  // Overflow is judged with the signedness of the sample being accumulated.
  always_comb begin
    if (tap.sgn) ext = ACC_WIDTH'(signed'(tap.prod));
    else         ext = ACC_WIDTH'(tap.prod);
    sum_s = {p_q[ACC_WIDTH-1], p_q} + {ext[ACC_WIDTH-1], ext};
    sum_u = {1'b0, p_q} + {1'b0, ext};
    p_d   = p_q;
    ovf_d = ovf_q;
    if (!tap.mode || tap.clr) begin
      p_d   = ext;
      ovf_d = 1'b0;
    end else if (tap.sgn) begin
      p_d = sum_s[ACC_WIDTH-1:0];
      if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) p_d = sum_s[ACC_WIDTH] ? SMIN : SMAX;
      end
    end else begin
      p_d = sum_u[ACC_WIDTH-1:0];
      if (sum_u[ACC_WIDTH]) begin
        ovf_d = 1'b1;
        if (SATURATE != 0) p_d = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q       <= '0;
      ovf_q     <= 1'b0;
      vld_out_q <= 1'b0;
    end else if (ce) begin
      vld_out_q <= tap.vld;
      if (tap.vld) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign P         = p_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_out_q;

endmodule
